serving_mem_sched: RTL

Sequential round-robin scheduler that shares the single-port serving RAM Wishbone port between three requesters: CPU ibus, CPU dbus, and an external DMA/loader port.
- Latches one request at a time and drives the memory port from registered copies.
- Returns a registered ack/rdt to the winning master only.
- Recovers from a non-responding memory with a timeout, completing the access with an error pulse.

---
 rtl/serving_sched_pkg.sv | 24 ++
 rtl/serving_rr_pick.sv | 34 +++
 rtl/serving_mem_sched.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/serving_sched_pkg.sv
// rtl/serving_sched_pkg.sv - shared master indices, state encoding and grant helpers for the serving RAM scheduler
package serving_sched_pkg;

  localparam int GW = 2;

  localparam logic [GW-1:0] M_IBUS = 2'd0;
  localparam logic [GW-1:0] M_DBUS = 2'd1;
  localparam logic [GW-1:0] M_DMA  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic [GW-1:0] gnt_idx(input logic [2:0] oh);
    logic [GW-1:0] idx;
    idx = M_IBUS;
    if (oh[M_DBUS]) idx = M_DBUS;
    if (oh[M_DMA])  idx = M_DMA;
    return idx;
  endfunction

endpackage

// File: rtl/serving_rr_pick.sv
// rtl/serving_rr_pick.sv - combinational 3-way round-robin picker; the master after i_last wins first
module serving_rr_pick
  import serving_sched_pkg::*;
(
  input  logic [2:0]    i_req,
  input  logic [GW-1:0] i_last,
  output logic [2:0]    o_gnt,
  output logic          o_valid
);

  always_comb begin
    o_gnt = '0;
    case (i_last)
      M_IBUS: begin
        if (i_req[M_DBUS])      o_gnt[M_DBUS] = 1'b1;
        else if (i_req[M_DMA])  o_gnt[M_DMA]  = 1'b1;
        else if (i_req[M_IBUS]) o_gnt[M_IBUS] = 1'b1;
      end
      M_DBUS: begin
        if (i_req[M_DMA])       o_gnt[M_DMA]  = 1'b1;
        else if (i_req[M_IBUS]) o_gnt[M_IBUS] = 1'b1;
        else if (i_req[M_DBUS]) o_gnt[M_DBUS] = 1'b1;
      end
      default: begin
        if (i_req[M_IBUS])      o_gnt[M_IBUS] = 1'b1;
        else if (i_req[M_DBUS]) o_gnt[M_DBUS] = 1'b1;
        else if (i_req[M_DMA])  o_gnt[M_DMA]  = 1'b1;
      end
    endcase
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/serving_mem_sched.sv
// rtl/serving_mem_sched.sv - round-robin arbiter sharing the serving RAM port between ibus, dbus and DMA
module serving_mem_sched
  import serving_sched_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 64,
  localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_ibus_adr,
  input  logic          i_ibus_stb,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_stb,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  input  logic [AW-1:0] i_dma_adr,
  input  logic [31:0]   i_dma_dat,
  input  logic [3:0]    i_dma_sel,
  input  logic          i_dma_we,
  input  logic          i_dma_stb,
  output logic [31:0]   o_dma_rdt,
  output logic          o_dma_ack,
  output logic [AW-1:0] o_mem_adr,
  output logic [31:0]   o_mem_dat,
  output logic [3:0]    o_mem_sel,
  output logic          o_mem_we,
  output logic          o_mem_stb,
  input  logic [31:0]   i_mem_rdt,
  input  logic          i_mem_ack,
  output logic          o_err
);

  localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]   ibus_rdt_q, ibus_rdt_d;
  logic [31:0]   dbus_rdt_q, dbus_rdt_d;
  logic [31:0]   dma_rdt_q, dma_rdt_d;
  logic [2:0]    ack_q, ack_d;
  logic          err_q, err_d;

  logic [2:0]    pick_gnt;
  logic          pick_valid;
  logic [GW-1:0] pick_idx;
  logic          timeout_hit;
  logic [31:0]   done_rdt;

  serving_rr_pick u_pick (
    .i_req   ({i_dma_stb, i_dbus_stb, i_ibus_stb}),
    .i_last  (last_q),
    .o_gnt   (pick_gnt),
    .o_valid (pick_valid)
  );

  assign pick_idx    = gnt_idx(pick_gnt);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  // Ack takes precedence over a timeout landing in the same cycle.
  assign done_rdt    = i_mem_ack ? i_mem_rdt : 32'h0;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    ibus_rdt_d = ibus_rdt_q;
    dbus_rdt_d = dbus_rdt_q;
    dma_rdt_d  = dma_rdt_q;
    ack_d      = '0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = ACTIVE;
          case (pick_idx)
            M_DBUS: begin
              adr_d = i_dbus_adr;
              dat_d = i_dbus_dat;
              sel_d = i_dbus_sel;
              we_d  = i_dbus_we;
            end
            M_DMA: begin
              adr_d = i_dma_adr;
              dat_d = i_dma_dat;
              sel_d = i_dma_sel;
              we_d  = i_dma_we;
            end
            default: begin
              adr_d = i_ibus_adr;
              dat_d = 32'h0;
              sel_d = 4'hf;
              we_d  = 1'b0;
            end
          endcase
        end
      end
      ACTIVE: begin
        if (i_mem_ack || timeout_hit) begin
          state_d = DONE;
          cnt_d   = '0;
          ack_d   = 3'b001 << gnt_q;
          err_d   = !i_mem_ack;
          case (gnt_q)
            M_DBUS:  dbus_rdt_d = done_rdt;
            M_DMA:   dma_rdt_d  = done_rdt;
            default: ibus_rdt_d = done_rdt;
          endcase
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      last_q     <= M_DMA;
      gnt_q      <= M_IBUS;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      ibus_rdt_q <= '0;
      dbus_rdt_q <= '0;
      dma_rdt_q  <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      ibus_rdt_q <= ibus_rdt_d;
      dbus_rdt_q <= dbus_rdt_d;
      dma_rdt_q  <= dma_rdt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign o_mem_stb  = (state_q == ACTIVE);
  assign o_mem_adr  = adr_q;
  assign o_mem_dat  = dat_q;
  assign o_mem_sel  = sel_q;
  assign o_mem_we   = we_q;
  assign o_ibus_rdt = ibus_rdt_q;
  assign o_dbus_rdt = dbus_rdt_q;
  assign o_dma_rdt  = dma_rdt_q;
  assign o_ibus_ack = ack_q[M_IBUS];
  assign o_dbus_ack = ack_q[M_DBUS];
  assign o_dma_ack  = ack_q[M_DMA];
  assign o_err      = err_q;

endmodule
